// File: rtl/pulse_divider_pkg.sv
// -----------------------------------------------------------------------------
// pulse_divider_pkg
//
// Shared definitions for the pulse divider:
//   mode_e      - output behaviour selected by the load port
//   state_e     - sequencer states of the top module
//   decode_mode - maps the raw 2-bit mode code onto mode_e (code 3 -> TICK)
// -----------------------------------------------------------------------------
package pulse_divider_pkg;

  typedef enum logic [1:0] {
    MODE_TICK   = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_BURST  = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The unused code 3 behaves exactly like TICK, so it is folded into TICK
  // when a configuration is latched. Later mode comparisons then treat 0 and 3
  // as the same mode.
  function automatic mode_e decode_mode(input logic [1:0] code);
    case (code)
      2'd1:    return MODE_SQUARE;
      2'd2:    return MODE_BURST;
      default: return MODE_TICK;
    endcase
  endfunction

endpackage

// File: rtl/pulse_divider_counter.sv
// -----------------------------------------------------------------------------
// pulse_counter
//
// WIDTH-bit period up-counter with a terminal-value compare.
//
// Ports:
//   clock   in   system clock, posedge
//   reset   in   synchronous active-high reset, counter -> 0
//   clear   in   counter -> 0 (has priority over inc)
//   inc     in   advance by one; holds at term instead of wrapping
//   term    in   terminal value (period length minus one)
//   at_term out  counter currently equals term
// -----------------------------------------------------------------------------
module pulse_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic [WIDTH-1:0] term,
  output logic             at_term
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != term)) begin
      // Saturating at term keeps the counter from ever wrapping, even if the
      // caller keeps asserting inc while sitting on the terminal value.
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_term = (count_q == term);

endmodule

// File: rtl/pulse_divider.sv
// -----------------------------------------------------------------------------
// pulse_divider
//
// Runtime-configurable clock divider producing a tick train, a square wave or
// a counted burst of ticks. New configurations are taken through a valid/ready
// port into a shadow register and only become active at a period boundary (or
// immediately when not running), so the output never glitches mid-period.
//
// Parameters:
//   WIDTH      width of divisor, burst count and internal counters
//   RESET_DIV  divisor in effect after reset (>= 1)
//
// Ports:
//   clock       in   system clock, posedge
//   reset       in   synchronous active-high reset
//   enable      in   run / pause control
//   cfg_mode    in   0 TICK, 1 SQUARE, 2 BURST, 3 TICK
//   cfg_div     in   divisor D (0 treated as 1)
//   cfg_count   in   burst length C (0 treated as 1)
//   load_valid  in   configuration offer
//   load_ready  out  shadow register free (no configuration pending)
//   signal      out  main output, registered
//   tick        out  one-cycle strobe per period boundary, registered
//   busy        out  sequencer in RUN
//   burst_done  out  sequencer in DONE
// -----------------------------------------------------------------------------
module pulse_divider
  import pulse_divider_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       cfg_mode,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_count,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             signal,
  output logic             tick,
  output logic             busy,
  output logic             burst_done
);

  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);
  localparam logic [WIDTH-1:0] RESET_DIV_W = WIDTH'(RESET_DIV);

  // Zero divisors and zero burst lengths behave as one; normalising at latch
  // time means the active registers never hold zero.
  function automatic logic [WIDTH-1:0] nonzero(input logic [WIDTH-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e           state_q,     state_d;
  mode_e            mode_q,      mode_d;
  logic [WIDTH-1:0] div_q,       div_d;
  logic [WIDTH-1:0] burst_q,     burst_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic             pending_q,   pending_d;
  mode_e            sh_mode_q,   sh_mode_d;
  logic [WIDTH-1:0] sh_div_q,    sh_div_d;
  logic [WIDTH-1:0] sh_burst_q,  sh_burst_d;
  logic             signal_q,    signal_d;
  logic             tick_q,      tick_d;

  // ---------------------------------------------------------------------------
  // Period counter
  // ---------------------------------------------------------------------------
  logic             at_term;
  logic             run_active;
  logic             boundary;
  logic             apply_cfg;
  logic             accept_cfg;
  logic             cnt_clear;
  logic             cnt_inc;
  logic [WIDTH-1:0] period_term;

  assign period_term = div_q - ONE;
  assign run_active  = (state_q == ST_RUN) && enable;
  assign boundary    = run_active && at_term;

  // Outside RUN there is no period in flight, so a pending configuration can
  // be taken straight away; inside RUN it waits for the end of the period.
  assign apply_cfg   = pending_q && ((state_q != ST_RUN) || boundary);
  assign accept_cfg  = load_valid && !pending_q;

  // The counter restarts on entry to RUN and at every boundary; while paused
  // neither strobe is active, so the phase is simply held.
  assign cnt_clear   = ((state_q == ST_IDLE) && enable) || boundary;
  assign cnt_inc     = run_active && !at_term;

  pulse_counter #(
    .WIDTH (WIDTH)
  ) u_period (
    .clock   (clock),
    .reset   (reset),
    .clear   (cnt_clear),
    .inc     (cnt_inc),
    .term    (period_term),
    .at_term (at_term)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    div_d       = div_q;
    burst_d     = burst_q;
    remaining_d = remaining_q;
    pending_d   = pending_q;
    sh_mode_d   = sh_mode_q;
    sh_div_d    = sh_div_q;
    sh_burst_d  = sh_burst_q;
    signal_d    = signal_q;
    tick_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d     = ST_RUN;
          remaining_d = burst_q;
          signal_d    = 1'b0;
        end
      end

      ST_RUN: begin
        if (boundary) begin
          tick_d = 1'b1;
          case (mode_q)
            MODE_SQUARE: begin
              signal_d = !signal_q;
            end
            MODE_BURST: begin
              signal_d = 1'b1;
              if (remaining_q != '0) begin
                remaining_d = remaining_q - ONE;
              end
              if (remaining_q == ONE) begin
                state_d = ST_DONE;
              end
            end
            default: begin
              signal_d = 1'b1;
            end
          endcase
        end else if (mode_q != MODE_SQUARE) begin
          // Strobe-style modes keep signal equal to tick, which is low on
          // every non-boundary edge (including paused ones). A square wave
          // instead holds its level across a pause.
          signal_d = 1'b0;
        end
      end

      ST_DONE: begin
        signal_d = 1'b0;
        if (!enable) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Applying a configuration overrides the per-mode actions above where the
    // two collide: a mode change forces signal low on the same edge, and a
    // BURST configuration restarts its count from the new length.
    if (apply_cfg) begin
      pending_d = 1'b0;
      mode_d    = sh_mode_q;
      div_d     = sh_div_q;
      burst_d   = sh_burst_q;
      if (sh_mode_q != mode_q) begin
        signal_d = 1'b0;
      end
      // The IDLE->RUN edge that also applies a configuration starts with the
      // newly applied burst length rather than the stale one.
      if ((sh_mode_q == MODE_BURST) || ((state_q == ST_IDLE) && enable)) begin
        remaining_d = sh_burst_q;
      end
    end

    // apply_cfg needs pending_q and accept_cfg needs !pending_q, so the two
    // never fire on the same edge and the shadow is never overwritten early.
    if (accept_cfg) begin
      pending_d  = 1'b1;
      sh_mode_d  = decode_mode(cfg_mode);
      sh_div_d   = nonzero(cfg_div);
      sh_burst_d = nonzero(cfg_count);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_TICK;
      div_q       <= RESET_DIV_W;
      burst_q     <= ONE;
      remaining_q <= '0;
      pending_q   <= 1'b0;
      sh_mode_q   <= MODE_TICK;
      sh_div_q    <= RESET_DIV_W;
      sh_burst_q  <= ONE;
      signal_q    <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      div_q       <= div_d;
      burst_q     <= burst_d;
      remaining_q <= remaining_d;
      pending_q   <= pending_d;
      sh_mode_q   <= sh_mode_d;
      sh_div_q    <= sh_div_d;
      sh_burst_q  <= sh_burst_d;
      signal_q    <= signal_d;
      tick_q      <= tick_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign load_ready = !pending_q;
  assign signal     = signal_q;
  assign tick       = tick_q;
  assign busy       = (state_q == ST_RUN);
  assign burst_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_pulse_divider.sv
// -----------------------------------------------------------------------------
// tb_pulse_divider
//
// Directed scenarios followed by a randomized run. A behavioural model tracks
// the elapsed cycles of the current period, the active and shadow
// configuration and the burst ticks left, and predicts all outputs; one
// process compares the DUT against it on every negative edge. Directed
// scenarios additionally check tick spacing against hand-computed cycle
// numbers.
// -----------------------------------------------------------------------------
module tb_pulse_divider;

  localparam int WIDTH     = 8;
  localparam int RESET_DIV = 1;

  logic             clock;
  logic             reset;
  logic             enable;
  logic [1:0]       cfg_mode;
  logic [WIDTH-1:0] cfg_div;
  logic [WIDTH-1:0] cfg_count;
  logic             load_valid;
  logic             load_ready;
  logic             signal;
  logic             tick;
  logic             busy;
  logic             burst_done;

  pulse_divider #(
    .WIDTH     (WIDTH),
    .RESET_DIV (RESET_DIV)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .cfg_mode   (cfg_mode),
    .cfg_div    (cfg_div),
    .cfg_count  (cfg_count),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .signal     (signal),
    .tick       (tick),
    .busy       (busy),
    .burst_done (burst_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int tick_q[$];

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  bit m_valid = 1'b0;
  bit m_run, m_fin;          // running a period train / burst finished
  int m_elapsed;             // edges since the current period started
  int m_left;                // burst ticks still to produce
  int a_mode, a_div, a_cnt;  // active configuration
  int s_mode, s_div, s_cnt;  // offered configuration waiting to be applied
  bit s_pend;
  bit m_sig, m_tick;
  bit rdy_m, bnd_m, app_m;

  function automatic int norm_mode(input int c);
    return (c == 1 || c == 2) ? c : 0;
  endfunction

  function automatic int nz(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      m_valid   = 1'b1;
      m_run     = 1'b0;
      m_fin     = 1'b0;
      m_elapsed = 0;
      m_left    = 0;
      a_mode    = 0;
      a_div     = RESET_DIV;
      a_cnt     = 1;
      s_mode    = 0;
      s_div     = RESET_DIV;
      s_cnt     = 1;
      s_pend    = 1'b0;
      m_sig     = 1'b0;
      m_tick    = 1'b0;
    end else if (m_valid) begin
      rdy_m  = !s_pend;
      bnd_m  = m_run && enable && (m_elapsed == a_div - 1);
      app_m  = s_pend && (!m_run || bnd_m);
      m_tick = 1'b0;
      if (!m_run && !m_fin) begin
        if (enable) begin
          m_run     = 1'b1;
          m_elapsed = 0;
          m_left    = app_m ? s_cnt : a_cnt;
          m_sig     = 1'b0;
        end
      end else if (m_fin) begin
        m_sig = 1'b0;
        if (!enable) m_fin = 1'b0;
      end else if (enable) begin
        if (bnd_m) begin
          m_elapsed = 0;
          m_tick    = 1'b1;
          m_sig     = (a_mode == 1) ? !m_sig : 1'b1;
          if (a_mode == 2) begin
            m_left--;
            if (m_left == 0) begin
              m_run = 1'b0;
              m_fin = 1'b1;
            end
          end
        end else begin
          m_elapsed++;
          if (a_mode != 1) m_sig = 1'b0;
        end
      end else if (a_mode != 1) begin
        m_sig = 1'b0;
      end
      if (app_m) begin
        if (s_mode != a_mode) m_sig = 1'b0;
        if (s_mode == 2) m_left = s_cnt;
        a_mode = s_mode;
        a_div  = s_div;
        a_cnt  = s_cnt;
        s_pend = 1'b0;
      end
      if (rdy_m && load_valid) begin
        s_mode = norm_mode(int'(cfg_mode));
        s_div  = nz(int'(cfg_div));
        s_cnt  = nz(int'(cfg_count));
        s_pend = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle comparison against the model
  // ---------------------------------------------------------------------------
  logic [4:0] got_v, exp_v;

  always @(negedge clock) begin
    if (m_valid) begin
      got_v = {signal, tick, busy, burst_done, load_ready};
      exp_v = {m_sig, m_tick, m_run, m_fin, !s_pend};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL outputs cyc=%0d sig/tick/busy/done/ready got %b expected %b",
                 cyc, got_v, exp_v);
      end
      if (tick === 1'b1) tick_q.push_back(cyc);
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic expect_eq(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc=%0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int qget(input int idx);
    return (idx < tick_q.size()) ? tick_q[idx] : -1;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    enable     = 1'b0;
    load_valid = 1'b0;
    step(1);
    reset = 1'b0;
  endtask

  task automatic load(input int mode, input int div, input int cnt);
    int guard;
    guard = 0;
    while (load_ready !== 1'b1 && guard < 500) begin
      step(1);
      guard++;
    end
    if (guard >= 500) expect_eq("load_ready_timeout", guard, 0);
    cfg_mode   = 2'(mode);
    cfg_div    = WIDTH'(div);
    cfg_count  = WIDTH'(cnt);
    load_valid = 1'b1;
    step(1);
    load_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int e0;

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    load_valid = 1'b0;
    cfg_mode   = '0;
    cfg_div    = '0;
    cfg_count  = '0;
    step(2);

    // Reset values
    do_reset();
    expect_eq("rst_load_ready", int'(load_ready), 1);
    expect_eq("rst_signal", int'(signal), 0);
    expect_eq("rst_tick", int'(tick), 0);
    expect_eq("rst_busy", int'(busy), 0);
    expect_eq("rst_burst_done", int'(burst_done), 0);

    // SQUARE D=3: toggle every 3 cycles, first tick 3 edges after RUN entry
    load(1, 3, 1);
    step(1);
    enable = 1'b1;
    step(1);
    for (int j = 1; j <= 12; j++) begin
      step(1);
      expect_eq($sformatf("sq3_tick_j%0d", j), int'(tick), (j % 3 == 0) ? 1 : 0);
      expect_eq($sformatf("sq3_sig_j%0d", j), int'(signal), (j / 3) % 2);
    end

    // TICK (code 3) D=1: strobe every cycle; then D=4 after current boundary
    do_reset();
    load(3, 1, 1);
    step(1);
    enable = 1'b1;
    step(1);
    for (int j = 1; j <= 4; j++) begin
      step(1);
      expect_eq("d1_tick", int'(tick), 1);
      expect_eq("d1_signal", int'(signal), 1);
    end
    load(0, 4, 1);
    e0 = cyc;
    tick_q.delete();
    step(14);
    expect_eq("d4_count", tick_q.size(), 4);
    expect_eq("d4_first", qget(0), e0 + 1);
    expect_eq("d4_gap0", qget(1) - qget(0), 4);
    expect_eq("d4_gap1", qget(2) - qget(1), 4);

    // BURST D=2 C=3, twice
    do_reset();
    load(2, 2, 3);
    step(1);
    enable = 1'b1;
    tick_q.delete();
    step(1);
    e0 = cyc;
    step(10);
    expect_eq("burst_count", tick_q.size(), 3);
    expect_eq("burst_first", qget(0), e0 + 2);
    expect_eq("burst_gap0", qget(1) - qget(0), 2);
    expect_eq("burst_gap1", qget(2) - qget(1), 2);
    expect_eq("burst_done_hi", int'(burst_done), 1);
    expect_eq("burst_busy_lo", int'(busy), 0);
    enable = 1'b0;
    step(1);
    expect_eq("burst_idle_done", int'(burst_done), 0);
    enable = 1'b1;
    tick_q.delete();
    step(12);
    expect_eq("burst2_count", tick_q.size(), 3);

    // Load on a boundary edge waits a period; second offer while pending ignored
    do_reset();
    load(1, 5, 1);
    step(1);
    enable = 1'b1;
    step(1);
    e0 = cyc;
    step(4);
    load(0, 2, 1);
    tick_q.delete();
    cfg_mode   = 2'd0;
    cfg_div    = WIDTH'(7);
    load_valid = 1'b1;
    step(1);
    load_valid = 1'b0;
    step(11);
    expect_eq("bnd_load_first", qget(0), e0 + 10);
    expect_eq("bnd_load_gap0", qget(1) - qget(0), 2);
    expect_eq("bnd_load_gap1", qget(2) - qget(1), 2);

    // Pause 5 cycles mid-period in SQUARE D=4
    do_reset();
    load(1, 4, 1);
    step(1);
    enable = 1'b1;
    step(1);
    e0 = cyc;
    step(6);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      expect_eq("pause_signal", int'(signal), 1);
      expect_eq("pause_tick", int'(tick), 0);
    end
    enable = 1'b1;
    tick_q.delete();
    step(10);
    expect_eq("resume_first", qget(0), e0 + 13);
    expect_eq("resume_second", qget(1), e0 + 17);

    // Reset mid-BURST with a configuration pending
    do_reset();
    load(2, 6, 5);
    step(1);
    enable = 1'b1;
    step(4);
    load(0, 2, 1);
    expect_eq("pend_ready_lo", int'(load_ready), 0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    expect_eq("mid_rst_ready", int'(load_ready), 1);
    expect_eq("mid_rst_busy", int'(busy), 0);
    expect_eq("mid_rst_signal", int'(signal), 0);
    expect_eq("mid_rst_tick", int'(tick), 0);
    step(1);
    tick_q.delete();
    step(6);
    expect_eq("mid_rst_d1_ticks", tick_q.size(), 6);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 299) == 0);
      enable     = ($urandom_range(0, 99) < 85);
      load_valid = ($urandom_range(0, 9) == 0);
      cfg_mode   = 2'($urandom_range(0, 3));
      cfg_div    = ($urandom_range(0, 15) == 0) ? WIDTH'($urandom_range(0, 30))
                                                : WIDTH'($urandom_range(0, 6));
      cfg_count  = WIDTH'($urandom_range(0, 4));
      step(1);
    end
    reset      = 1'b0;
    load_valid = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
